// File: rtl/posit_extract_pipe.sv
// Two-stage pipelined posit field extractor: sign, zero/NaR flags, signed scale,
// left-aligned fraction and magnitude, with valid/ready handshaking and a sideband tag.
module posit_extract_pipe #(
   parameter int NBITS = 32,
   parameter int ES    = 2,
   parameter int TAG_W = 8,
   localparam int FW   = NBITS - ES - 3,
   localparam int SW   = $clog2(NBITS) + ES + 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NBITS-1:0] in_posit,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sgn,
   output logic             out_zero,
   output logic             out_inf,
   output logic [SW-1:0]    out_scale,
   output logic [FW-1:0]    out_fraction,
   output logic [NBITS-2:0] out_abs,
   output logic [TAG_W-1:0] out_tag
);

   localparam int MW = NBITS - 1;
   localparam int RW = $clog2(NBITS) + 1;

   logic             s1_en;
   logic             s2_en;

   logic             s1_valid_q, s1_valid_d;
   logic             s1_sgn_q, s1_sgn_d;
   logic             s1_zero_q, s1_zero_d;
   logic             s1_inf_q, s1_inf_d;
   logic [MW-1:0]    s1_abs_q, s1_abs_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             s2_valid_q, s2_valid_d;
   logic             s2_sgn_q, s2_sgn_d;
   logic             s2_zero_q, s2_zero_d;
   logic             s2_inf_q, s2_inf_d;
   logic [SW-1:0]    s2_scale_q, s2_scale_d;
   logic [FW-1:0]    s2_frac_q, s2_frac_d;
   logic [MW-1:0]    s2_abs_q, s2_abs_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

   logic             regime_bit;
   logic [MW-1:0]    run_vec;
   logic [RW-1:0]    run;
   logic [SW-1:0]    k_val;
   logic [MW-3:0]    rest;
   logic [SW-1:0]    e_ext;
   logic [SW-1:0]    scale;
   logic [FW-1:0]    frac;

   // A stage may load when it is empty or when its current content moves on.
   always_comb begin
      s2_en    = !s2_valid_q || out_ready;
      s1_en    = !s1_valid_q || s2_en;
      in_ready = reset_n && s1_en;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sgn_d   = s1_sgn_q;
      s1_zero_d  = s1_zero_q;
      s1_inf_d   = s1_inf_q;
      s1_abs_d   = s1_abs_q;
      s1_tag_d   = s1_tag_q;
      if (s1_en) begin
         s1_valid_d = in_valid;
      end
      if (s1_en && in_valid) begin
         s1_sgn_d  = in_posit[NBITS-1];
         s1_zero_d = (in_posit == '0);
         s1_inf_d  = (in_posit == {1'b1, {MW{1'b0}}});
         // Low MW bits of the two's complement negation; NaR collapses to 0.
         s1_abs_d  = in_posit[NBITS-1] ? (~in_posit[MW-1:0] + MW'(1)) : in_posit[MW-1:0];
         s1_tag_d  = in_tag;
      end
   end

   // Regime: count leading bits equal to the first magnitude bit.
   always_comb begin
      regime_bit = s1_abs_q[MW-1];
      run_vec    = regime_bit ? ~s1_abs_q : s1_abs_q;
      run        = RW'(MW);
      for (int i = 0; i < MW; i++) begin
         if (run_vec[i]) begin
            run = RW'(MW - 1 - i);
         end
      end
      k_val = regime_bit ? (SW'(run) - SW'(1)) : (SW'(0) - SW'(run));
      // Drop regime and terminator; bits pushed past the end read as zero.
      rest  = s1_abs_q[MW-3:0] << (run - RW'(1));
   end

   generate
      if (ES > 0) begin : g_exp
         assign e_ext = SW'(rest[MW-3 -: ES]);
      end else begin : g_no_exp
         assign e_ext = '0;
      end
   endgenerate

   always_comb begin
      scale = (k_val << ES) + e_ext;
      frac  = rest[FW-1:0];
      if (s1_zero_q || s1_inf_q) begin
         scale = '0;
         frac  = '0;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_sgn_d   = s2_sgn_q;
      s2_zero_d  = s2_zero_q;
      s2_inf_d   = s2_inf_q;
      s2_scale_d = s2_scale_q;
      s2_frac_d  = s2_frac_q;
      s2_abs_d   = s2_abs_q;
      s2_tag_d   = s2_tag_q;
      if (s2_en) begin
         s2_valid_d = s1_valid_q;
      end
      if (s2_en && s1_valid_q) begin
         s2_sgn_d   = s1_sgn_q;
         s2_zero_d  = s1_zero_q;
         s2_inf_d   = s1_inf_q;
         s2_scale_d = scale;
         s2_frac_d  = frac;
         s2_abs_d   = s1_abs_q;
         s2_tag_d   = s1_tag_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_sgn_q   <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_inf_q   <= 1'b0;
         s1_abs_q   <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_sgn_q   <= 1'b0;
         s2_zero_q  <= 1'b0;
         s2_inf_q   <= 1'b0;
         s2_scale_q <= '0;
         s2_frac_q  <= '0;
         s2_abs_q   <= '0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sgn_q   <= s1_sgn_d;
         s1_zero_q  <= s1_zero_d;
         s1_inf_q   <= s1_inf_d;
         s1_abs_q   <= s1_abs_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_sgn_q   <= s2_sgn_d;
         s2_zero_q  <= s2_zero_d;
         s2_inf_q   <= s2_inf_d;
         s2_scale_q <= s2_scale_d;
         s2_frac_q  <= s2_frac_d;
         s2_abs_q   <= s2_abs_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_sgn      = s2_sgn_q;
   assign out_zero     = s2_zero_q;
   assign out_inf      = s2_inf_q;
   assign out_scale    = s2_scale_q;
   assign out_fraction = s2_frac_q;
   assign out_abs      = s2_abs_q;
   assign out_tag      = s2_tag_q;

endmodule

// File: tb/tb_posit_extract_pipe.sv
// Directed and swept checks of posit_extract_pipe at NBITS=8/ES=2 and NBITS=16/ES=1.
module tb_posit_extract_pipe;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // 8-bit, ES=2 instance: FW=3, SW=7
   logic       in_valid, in_ready, out_valid, out_ready;
   logic       out_sgn, out_zero, out_inf;
   logic [7:0] in_posit, in_tag, out_tag;
   logic [6:0] out_scale, out_abs;
   logic [2:0] out_fraction;

   // 16-bit, ES=1 instance: FW=12, SW=7
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic        b_out_sgn, b_out_zero, b_out_inf;
   logic [15:0] b_in_posit;
   logic [7:0]  b_in_tag, b_out_tag;
   logic [6:0]  b_out_scale;
   logic [11:0] b_out_fraction;
   logic [14:0] b_out_abs;

   int checks = 0;
   int errors = 0;

   posit_extract_pipe #(.NBITS(8), .ES(2), .TAG_W(8)) dut8 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sgn(out_sgn), .out_zero(out_zero), .out_inf(out_inf),
      .out_scale(out_scale), .out_fraction(out_fraction), .out_abs(out_abs), .out_tag(out_tag)
   );

   posit_extract_pipe #(.NBITS(16), .ES(1), .TAG_W(8)) dut16 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_posit(b_in_posit), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sgn(b_out_sgn), .out_zero(b_out_zero), .out_inf(b_out_inf),
      .out_scale(b_out_scale), .out_fraction(b_out_fraction), .out_abs(b_out_abs), .out_tag(b_out_tag)
   );

   // Hand-computed vectors for NBITS=8, ES=2
   logic [7:0] v_posit [10] = '{8'h40, 8'h50, 8'h2A, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hC0, 8'hD6, 8'h7E};
   int         v_scale [10] = '{0, 2, -3, 0, 0, 24, -24, 0, -3, 20};
   bit         v_sgn   [10] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
   bit         v_zero  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
   bit         v_inf   [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
   logic [2:0] v_frac  [10] = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
   logic [6:0] v_abs   [10] = '{7'h40, 7'h50, 7'h2A, 7'h00, 7'h00, 7'h7F, 7'h01, 7'h40, 7'h2A, 7'h7E};

   // Bit-serial reference decoder, independent of the RTL structure
   function automatic void model(input longint unsigned p_in, input int nb, input int es,
                                 output bit sgn, output bit zero, output bit inf, output int scale,
                                 output longint unsigned frac, output longint unsigned absv);
      longint unsigned mask, p, a;
      int i, run, k, e;
      bit r0;
      mask = (64'd1 << nb) - 64'd1;
      p    = p_in & mask;
      sgn  = p[nb-1];
      zero = (p == 0);
      inf  = (p == (64'd1 << (nb - 1)));
      a    = sgn ? ((~p + 64'd1) & mask) : p;
      absv = a & (mask >> 1);
      scale = 0;
      frac  = 0;
      if (zero || inf) return;
      i = nb - 2;
      r0 = a[i];
      run = 0;
      while (i >= 0 && a[i] == r0) begin
         run++;
         i--;
      end
      k = r0 ? run - 1 : -run;
      i--;
      e = 0;
      for (int j = 0; j < es; j++) begin
         e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
         i--;
      end
      for (int j = 0; j < nb - es - 3; j++) begin
         frac = frac * 2 + ((i >= 0) ? longint'(a[i]) : 0);
         i--;
      end
      scale = k * (1 << es) + e;
   endfunction

   task automatic test_reset;
      reset_n = 1'b0;
      in_valid = 1'b0; in_posit = '0; in_tag = '0; out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_posit = '0; b_in_tag = '0; b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, b_out_valid, b_in_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000", {out_valid, in_ready, b_out_valid, b_in_ready});
      end
      checks++;
      if ({out_tag, out_scale, out_abs} !== 22'h0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", {out_tag, out_scale, out_abs});
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b want 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      for (int n = 0; n <= 3; n++) begin
         in_valid = (n < 3);
         in_posit = v_posit[n % 3];
         in_tag   = 8'(n + 1);
         #1;
         if (n < 3) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_in_ready n=%0d got %b want 1", n, in_ready);
            end
         end
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'(n >= 1)) begin
            errors++;
            $display("FAIL b2b_latency n=%0d out_valid got %b want %b", n, out_valid, 1'(n >= 1));
         end
         if (n >= 1) begin
            $display("txn b2b posit=%h tag=%h scale=%0d frac=%b", v_posit[n-1], out_tag, $signed(out_scale), out_fraction);
            checks++;
            if ({out_sgn, out_zero, out_inf, out_scale, out_fraction, out_abs, out_tag} !==
                {v_sgn[n-1], v_zero[n-1], v_inf[n-1], 7'(v_scale[n-1]), v_frac[n-1], v_abs[n-1], 8'(n)}) begin
               errors++;
               $display("FAIL b2b_fields posit=%h got %b%b%b/%0d/%b/%h/%h want %b%b%b/%0d/%b/%h/%h",
                        v_posit[n-1], out_sgn, out_zero, out_inf, $signed(out_scale), out_fraction, out_abs, out_tag,
                        v_sgn[n-1], v_zero[n-1], v_inf[n-1], v_scale[n-1], v_frac[n-1], v_abs[n-1], 8'(n));
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_special;
      int j;
      out_ready = 1'b1;
      for (int n = 0; n <= 7; n++) begin
         in_valid = (n < 7);
         in_posit = v_posit[3 + (n % 7)];
         in_tag   = 8'(8'h30 + n);
         @(posedge clk);
         #1;
         if (n >= 1) begin
            j = 3 + n - 1;
            $display("txn special posit=%h tag=%h scale=%0d frac=%b", v_posit[j], out_tag, $signed(out_scale), out_fraction);
            checks++;
            if ({out_valid, out_sgn, out_zero, out_inf, out_scale, out_fraction, out_abs, out_tag} !==
                {1'b1, v_sgn[j], v_zero[j], v_inf[j], 7'(v_scale[j]), v_frac[j], v_abs[j], 8'(8'h30 + n - 1)}) begin
               errors++;
               $display("FAIL special_fields posit=%h got v%b %b%b%b/%0d/%b/%h/%h want %b%b%b/%0d/%b/%h",
                        v_posit[j], out_valid, out_sgn, out_zero, out_inf, $signed(out_scale), out_fraction, out_abs,
                        out_tag, v_sgn[j], v_zero[j], v_inf[j], v_scale[j], v_frac[j], v_abs[j]);
            end
         end
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      in_valid = 1'b1; in_posit = v_posit[1]; in_tag = 8'h11;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_posit = v_posit[2]; in_tag = 8'h22;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_posit = v_posit[5]; in_tag = 8'h33;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready c=%0d got %b want 0", c, in_ready); end
         checks++;
         if ({out_valid, out_tag, out_scale, out_abs} !== {1'b1, 8'h11, 7'd2, 7'h50}) begin
            errors++;
            $display("FAIL bp_frozen c=%0d got v%b tag=%h scale=%0d abs=%h want v1 tag=11 scale=2 abs=50",
                     c, out_valid, out_tag, $signed(out_scale), out_abs);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      $display("txn bp posit=2a tag=%h scale=%0d", out_tag, $signed(out_scale));
      checks++;
      if ({out_valid, out_tag, out_scale, out_fraction} !== {1'b1, 8'h22, 7'(-3), 3'b010}) begin
         errors++;
         $display("FAIL bp_second got v%b tag=%h scale=%0d frac=%b want v1 tag=22 scale=-3 frac=010",
                  out_valid, out_tag, $signed(out_scale), out_fraction);
      end
      @(posedge clk); #1;
      $display("txn bp posit=7f tag=%h scale=%0d", out_tag, $signed(out_scale));
      checks++;
      if ({out_valid, out_tag, out_scale, out_fraction} !== {1'b1, 8'h33, 7'd24, 3'b000}) begin
         errors++;
         $display("FAIL bp_third got v%b tag=%h scale=%0d frac=%b want v1 tag=33 scale=24 frac=000",
                  out_valid, out_tag, $signed(out_scale), out_fraction);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", out_valid); end
   endtask

   task automatic test_reset_midflight;
      out_ready = 1'b0;
      in_valid = 1'b1; in_posit = v_posit[1]; in_tag = 8'hA1;
      @(posedge clk); #1;
      in_posit = v_posit[2]; in_tag = 8'hA2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
         errors++;
         $display("FAIL mid_full got %b want 10", {out_valid, in_ready});
      end
      reset_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
         errors++;
         $display("FAIL mid_reset got %b want 00", {out_valid, in_ready});
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_dropped c=%0d out_valid got %b want 0", c, out_valid);
         end
      end
   endtask

   task automatic test_sweep8;
      logic [7:0] qp[$];
      logic [7:0] qt[$];
      logic [7:0] p, t;
      int sent, got, cyc, sc;
      bit in_fire, out_fire, s, z, f;
      longint unsigned fr, ab;
      sent = 0; got = 0; cyc = 0;
      in_valid = 1'b0;
      while (got < 256 && cyc < 8000) begin
         if (!in_valid) begin
            in_valid = (sent < 256) && ($urandom_range(0, 3) != 0);
            in_posit = 8'(sent);
            in_tag   = 8'(sent);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         in_fire  = in_valid && in_ready;
         out_fire = out_valid && out_ready;
         if (out_fire) begin
            checks++;
            if (qp.size() == 0) begin
               errors++;
               $display("FAIL sweep8_unexpected tag=%h got output want none", out_tag);
            end else begin
               p = qp.pop_front();
               t = qt.pop_front();
               model(longint'(p), 8, 2, s, z, f, sc, fr, ab);
               $display("txn sweep8 posit=%h tag=%h scale=%0d frac=%b", p, out_tag, $signed(out_scale), out_fraction);
               if ({out_sgn, out_zero, out_inf, out_scale, out_fraction, out_abs, out_tag} !==
                   {s, z, f, 7'(sc), 3'(fr), 7'(ab), t}) begin
                  errors++;
                  $display("FAIL sweep8 posit=%h got %b%b%b/%0d/%b/%h/%h want %b%b%b/%0d/%b/%h/%h",
                           p, out_sgn, out_zero, out_inf, $signed(out_scale), out_fraction, out_abs, out_tag,
                           s, z, f, sc, 3'(fr), 7'(ab), t);
               end
            end
            got++;
         end
         @(posedge clk); #1;
         cyc++;
         if (in_fire) begin
            qp.push_back(in_posit);
            qt.push_back(in_tag);
            sent++;
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 256) begin errors++; $display("FAIL sweep8_count got %0d want 256", got); end
   endtask

   task automatic test_sweep16;
      logic [15:0] vals[$];
      logic [15:0] qp[$];
      logic [7:0]  qt[$];
      logic [15:0] p;
      logic [7:0]  t;
      int sent, got, cyc, sc;
      bit in_fire, out_fire, s, z, f;
      longint unsigned fr, ab;
      vals = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h4000, 16'h7FFE, 16'h8001};
      while (vals.size() < 1000) vals.push_back(16'($urandom));
      sent = 0; got = 0; cyc = 0;
      b_in_valid = 1'b0;
      while (got < 1000 && cyc < 30000) begin
         if (!b_in_valid) begin
            b_in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            b_in_posit = vals[sent % 1000];
            b_in_tag   = 8'(sent);
         end
         b_out_ready = ($urandom_range(0, 3) != 0);
         #1;
         in_fire  = b_in_valid && b_in_ready;
         out_fire = b_out_valid && b_out_ready;
         if (out_fire) begin
            checks++;
            if (qp.size() == 0) begin
               errors++;
               $display("FAIL sweep16_unexpected tag=%h got output want none", b_out_tag);
            end else begin
               p = qp.pop_front();
               t = qt.pop_front();
               model(longint'(p), 16, 1, s, z, f, sc, fr, ab);
               $display("txn sweep16 posit=%h tag=%h scale=%0d frac=%h", p, b_out_tag, $signed(b_out_scale), b_out_fraction);
               if ({b_out_sgn, b_out_zero, b_out_inf, b_out_scale, b_out_fraction, b_out_abs, b_out_tag} !==
                   {s, z, f, 7'(sc), 12'(fr), 15'(ab), t}) begin
                  errors++;
                  $display("FAIL sweep16 posit=%h got %b%b%b/%0d/%h/%h/%h want %b%b%b/%0d/%h/%h/%h",
                           p, b_out_sgn, b_out_zero, b_out_inf, $signed(b_out_scale), b_out_fraction, b_out_abs,
                           b_out_tag, s, z, f, sc, 12'(fr), 15'(ab), t);
               end
            end
            got++;
         end
         @(posedge clk); #1;
         cyc++;
         if (in_fire) begin
            qp.push_back(b_in_posit);
            qt.push_back(b_in_tag);
            sent++;
            b_in_valid = 1'b0;
         end
      end
      b_in_valid = 1'b0;
      checks++;
      if (got !== 1000) begin errors++; $display("FAIL sweep16_count got %0d want 1000", got); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_special();
      test_backpressure();
      test_reset_midflight();
      test_sweep8();
      test_sweep16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
